// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

    // Clock frequency in MHz; the default stall limit is 1 ms of clk cycles.
    localparam int unsigned CLK_FREQ               = 27;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = CLK_FREQ * 1000;

    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Source-side and uart_tx-side handshake bundle of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    import uart_arb_pkg::*;

    localparam int unsigned GW = grant_w(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_enable;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_data_valid;
    logic                 tx_data_ready;
    logic [GW-1:0]        grant_id;
    logic                 busy;
    logic                 timeout_pulse;

    modport master (
        output req_valid, req_data, req_last, req_enable, tx_data_ready,
        input  req_ready, tx_data, tx_data_valid, grant_id, busy, timeout_pulse
    );

    modport slave (
        input  req_valid, req_data, req_last, req_enable, tx_data_ready,
        output req_ready, tx_data, tx_data_valid, grant_id, busy, timeout_pulse
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first candidate found searching upward from last_grant+1.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned GW     = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] candidates,
    input  logic [GW-1:0]      last_grant,
    output logic               any,
    output logic [GW-1:0]      pick_id
);

    int unsigned idx;

    always_comb begin
        any     = |candidates;
        pick_id = '0;
        idx     = '0;
        // Walk from the farthest offset inward so the nearest candidate overwrites last.
        for (int unsigned off = NUM_REQ; off >= 1; off--) begin
            idx = (32'(last_grant) + off) % NUM_REQ;
            if (candidates[idx[GW-1:0]]) begin
                pick_id = idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx among NUM_REQ sources.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned      GW         = grant_w(NUM_REQ);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int unsigned      CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_t         state;
    logic [7:0]         tx_data;
    logic               tx_data_valid;
    logic [GW-1:0]      grant_id;
    logic [GW-1:0]      last_grant;
    logic               busy;
    logic               timeout_pulse;
    logic               last_flag;
    logic [CNT_W-1:0]   stall_cnt;

    logic [NUM_REQ-1:0] candidates;
    logic               any;
    logic [GW-1:0]      pick_id;
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic               load;
    logic               xfer;
    logic               stall;
    logic               timeout_hit;
    logic [NUM_REQ-1:0] req_ready;

    assign candidates = bus.req_valid & bus.req_enable;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .candidates (candidates),
        .last_grant (last_grant),
        .any        (any),
        .pick_id    (pick_id)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GW'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    assign load        = busy & ~tx_data_valid & bus.tx_data_ready & sel_valid;
    assign xfer        = tx_data_valid & bus.tx_data_ready;
    assign stall       = busy & ~tx_data_valid & ~sel_valid;
    assign timeout_hit = TIMEOUT_EN && stall && (stall_cnt == CNT_LIMIT);

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = load && (grant_id == GW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            last_grant    <= GW'(NUM_REQ - 1);
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            last_flag     <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        grant_id <= pick_id;
                        busy     <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // load and xfer are exclusive (load needs tx_data_valid low), and a
                    // stall needs req_valid low, so load always beats a timeout.
                    if (load) begin
                        tx_data       <= sel_data;
                        tx_data_valid <= 1'b1;
                        last_flag     <= sel_last;
                        stall_cnt     <= '0;
                    end else if (xfer) begin
                        tx_data_valid <= 1'b0;
                        stall_cnt     <= '0;
                        if (last_flag) begin
                            last_grant <= grant_id;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end else if (timeout_hit) begin
                        timeout_pulse <= 1'b1;
                        last_grant    <= grant_id;
                        busy          <= 1'b0;
                        stall_cnt     <= '0;
                        state         <= ST_IDLE;
                    end else if (stall) begin
                        if (stall_cnt != '1) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.tx_data       = tx_data;
    assign bus.tx_data_valid = tx_data_valid;
    assign bus.grant_id      = grant_id;
    assign bus.busy          = busy;
    assign bus.timeout_pulse = timeout_pulse;

endmodule
